multi_tone_analyzer: RTL and testbench
======================================

MULTI_TONE_ANALYZER -- requirements
Module: multi_tone_analyzer

Interface
REQ-001 SHALL have parameter NUM_TONES, default 2: number of tone bins, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: half-period counter width.
REQ-003 SHALL have parameter ACC_W, default 32: per-tone accumulator width.
REQ-004 SHALL have parameter WINDOW_TICKS, default 50000000: measurement window length in clock cycles.
REQ-005 SHALL have parameter TOL_SHIFT, default 3: tolerance = target >> TOL_SHIFT.
REQ-006 SHALL have port clock, input, 1: single clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clear, input, 1: synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1: run measurement while high.
REQ-009 SHALL have port sample_data, input, 1: tone input.
REQ-010 SHALL have port cfg_half_period, input, NUM_TONES*CNT_W: per-tone target half-period in cycles; bin i at [i*CNT_W +: CNT_W].
REQ-011 SHALL have port result_ticks, output, NUM_TONES*ACC_W: per-tone accumulated matched ticks.
REQ-012 SHALL have port result_miss, output, ACC_W: accumulated unmatched ticks.
REQ-013 SHALL have port result_dom / result_dom_vld, output, 3 / 1: dominant tone index / index is meaningful.
REQ-014 SHALL have port result_valid / result_ready, output / input, 1 / 1: result handshake.
REQ-015 SHALL have port result_overrun, output, 1: the current result overwrote an unconsumed result.

Function
REQ-016 SHALL implement FSM IDLE, ARM, MEASURE; enable low in any state -> IDLE next cycle, discarding partial accumulation.
REQ-017 IDLE: enable high -> ARM; window counter loads 0.
REQ-018 ARM: SHALL wait for the first sample_data edge (either polarity), then -> MEASURE with half-period counter = 1; the partial first half-period is discarded.
REQ-019 MEASURE: half-period counter SHALL increment each cycle without an edge and saturate at 2^CNT_W-1; on an edge the counter value H SHALL be classified, then the counter reloads 1.
REQ-020 Classification: bin i matches if |H - T_i| <= (T_i >> TOL_SHIFT); lowest matching index wins; a saturated H or T_i = 0 never matches.
REQ-021 Matched H SHALL be added to acc[i]; unmatched H to miss; all accumulators saturate at 2^ACC_W-1.
REQ-022 Window counter SHALL run in ARM and MEASURE; at count WINDOW_TICKS-1 it SHALL snapshot accumulators to result outputs, clear accumulators, reset window to 0, and stay in the current state.
REQ-023 An edge classified in the window-end cycle SHALL be included in that snapshot.
REQ-024 result_dom SHALL be the index of the largest snapshotted acc, ties to lowest index; result_dom_vld = 0 when all acc are zero.
REQ-025 result_valid SHALL rise the cycle after snapshot and hold until a cycle with result_ready high; results SHALL be stable while valid.
REQ-026 A snapshot while result_valid && !result_ready SHALL overwrite the results and set result_overrun = 1; a snapshot with no pending result SHALL set result_overrun = 0.
REQ-027 Result latency: window end -> result_valid = 1 cycle (plus 2 with sync, REQ-031).

Reset
REQ-028 On clear: state IDLE; all counters, accumulators, result_ticks, result_miss, result_dom = 0; result_dom_vld, result_valid, result_overrun = 0.
REQ-029 clear SHALL take priority over enable and result_ready; clear mid-window SHALL discard the window with no result emitted.

Configuration
REQ-030 Macro MULTI_TONE_ANALYZER_SYNC_EN SHALL be the sole compile option.
REQ-031 Defined: sample_data passes a 2-FF synchronizer before edge detection (+2 cycles edge latency). Undefined: sample_data is registered once for edge detection with no synchronizer; caller guarantees synchronous input.

Structure
REQ-032 Package freq_analyzer_pkg SHALL hold FSM state encoding, max NUM_TONES constant (8), and dominant-index width (3).
REQ-033 Sub-module tone_matcher SHALL implement one bin's combinational window compare (H, T_i, TOL_SHIFT -> match), instantiated NUM_TONES times.

Verification (NUM_TONES=2, CNT_W=16, ACC_W=32, WINDOW_TICKS=1000, TOL_SHIFT=2, targets T0=10, T1=25; sync disabled)
REQ-034 Square wave with half-period 10, result_ready=1 -> result_valid pulses once per 1000 cycles; acc0 in 970..1000; acc1 = 0; result_dom = 0, result_dom_vld = 1.
REQ-035 Half-period 27 (inside T1 +/-6) -> acc1 > 0, acc0 = 0, result_dom = 1; half-period 40 -> miss > 0, both acc = 0, result_dom_vld = 0.
REQ-036 result_ready=0 across two window ends -> second result visible with result_overrun = 1; ready for one cycle -> valid drops; the next result has result_overrun = 0.
REQ-037 Constant sample_data for a full window -> FSM stays in ARM; result all zero, result_dom_vld = 0.
REQ-038 clear asserted at cycle 500 of a window -> next cycle all outputs zero, state IDLE; no result_valid for that window.
REQ-039 enable dropped mid-window then reasserted -> no result until a full 1000-cycle window elapses after re-arming.

Source files
------------

// File: rtl/multi_tone_analyzer_pkg.sv
// Shared FSM encoding and limits for the multi-tone analyzer.
package freq_analyzer_pkg;

  localparam int MAX_TONES = 8;
  localparam int DOM_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/multi_tone_analyzer_if.sv
// Result bundle of the multi-tone analyzer; master = analyzer, slave = consumer.
interface multi_tone_analyzer_if #(
  parameter int NUM_TONES = 2,
  parameter int ACC_W     = 32
);
  import freq_analyzer_pkg::*;

  logic [NUM_TONES*ACC_W-1:0] result_ticks;
  logic [ACC_W-1:0]           result_miss;
  logic [DOM_W-1:0]           result_dom;
  logic                       result_dom_vld;
  logic                       result_valid;
  logic                       result_ready;
  logic                       result_overrun;

  modport master (
    output result_ticks,
    output result_miss,
    output result_dom,
    output result_dom_vld,
    output result_valid,
    output result_overrun,
    input  result_ready
  );

  modport slave (
    input  result_ticks,
    input  result_miss,
    input  result_dom,
    input  result_dom_vld,
    input  result_valid,
    input  result_overrun,
    output result_ready
  );

endinterface

// File: rtl/multi_tone_analyzer_tone_matcher.sv
// One tone bin: matches when |H - T| <= T >> TOL_SHIFT; a zero target or saturated H never match.
module tone_matcher #(
  parameter int CNT_W     = 16,
  parameter int TOL_SHIFT = 3
) (
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] target,
  output logic             match
);

  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] tol;

  always_comb begin
    diff  = (half_period >= target) ? (half_period - target) : (target - half_period);
    tol   = target >> TOL_SHIFT;
    match = (target != '0) && (half_period != '1) && (diff <= tol);
  end

endmodule

// File: rtl/multi_tone_analyzer.sv
// Multi-tone analyzer: bins sample_data half-periods by target tone over fixed windows.
// Compile option MULTI_TONE_ANALYZER_SYNC_EN inserts a 2-FF synchronizer on sample_data.
module multi_tone_analyzer
  import freq_analyzer_pkg::*;
#(
  parameter int NUM_TONES    = 2,
  parameter int CNT_W        = 16,
  parameter int ACC_W        = 32,
  parameter int WINDOW_TICKS = 50000000,
  parameter int TOL_SHIFT    = 3
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       sample_data,
  input  logic [NUM_TONES*CNT_W-1:0] cfg_half_period,
  multi_tone_analyzer_if.master      res
);

  localparam int               WIN_W    = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int               SUM_W    = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] HP_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HP_MAX   = '1;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  state_t                     state_q, state_d;
  logic                       tone_edge;
  logic                       running;
  logic                       win_end;
  logic [WIN_W-1:0]           win_q;
  logic [CNT_W-1:0]           hp_q;
  logic [ACC_W-1:0]           acc_q   [NUM_TONES];
  logic [ACC_W-1:0]           acc_sum [NUM_TONES];
  logic [ACC_W-1:0]           miss_q, miss_sum;
  logic [NUM_TONES-1:0]       match_vec;
  logic                       found;
  logic [NUM_TONES*ACC_W-1:0] ticks_snap;
  logic [ACC_W-1:0]           dom_max;
  logic [DOM_W-1:0]           dom_idx;
  logic                       dom_any;

  logic [NUM_TONES*ACC_W-1:0] res_ticks_q;
  logic [ACC_W-1:0]           res_miss_q;
  logic [DOM_W-1:0]           res_dom_q;
  logic                       res_dom_vld_q;
  logic                       res_valid_q;
  logic                       res_overrun_q;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(ACC_MAX)) return ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

`ifdef MULTI_TONE_ANALYZER_SYNC_EN
  logic [2:0] sync_q;

  always_ff @(posedge clock) begin
    if (clear) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], sample_data};
  end

  assign tone_edge = sync_q[2] ^ sync_q[1];
`else
  logic sample_q;

  always_ff @(posedge clock) begin
    if (clear) sample_q <= 1'b0;
    else       sample_q <= sample_data;
  end

  assign tone_edge = sample_data ^ sample_q;
`endif

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (tone_edge) state_d = ST_MEASURE;
        ST_MEASURE: state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign running = enable && (state_q != ST_IDLE);
  assign win_end = running && (win_q == WIN_LAST);

  for (genvar g = 0; g < NUM_TONES; g++) begin : g_bin
    tone_matcher #(
      .CNT_W     (CNT_W),
      .TOL_SHIFT (TOL_SHIFT)
    ) u_match (
      .half_period (hp_q),
      .target      (cfg_half_period[g*CNT_W +: CNT_W]),
      .match       (match_vec[g])
    );
  end

  // Accumulator values including this cycle's edge, so a window-end edge lands in the snapshot.
  always_comb begin
    found    = 1'b0;
    acc_sum  = acc_q;
    miss_sum = miss_q;
    if (state_q == ST_MEASURE && tone_edge) begin
      for (int i = 0; i < NUM_TONES; i++) begin
        if (match_vec[i] && !found) begin
          acc_sum[i] = sat_add(acc_q[i], hp_q);
          found      = 1'b1;
        end
      end
      if (!found) miss_sum = sat_add(miss_q, hp_q);
    end
  end

  always_comb begin
    ticks_snap = '0;
    dom_idx    = '0;
    dom_max    = acc_sum[0];
    dom_any    = (acc_sum[0] != '0);
    for (int i = 0; i < NUM_TONES; i++) begin
      ticks_snap[i*ACC_W +: ACC_W] = acc_sum[i];
    end
    for (int i = 1; i < NUM_TONES; i++) begin
      if (acc_sum[i] > dom_max) begin
        dom_max = acc_sum[i];
        dom_idx = DOM_W'(i);
      end
      if (acc_sum[i] != '0) dom_any = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hp_q   <= '0;
      win_q  <= '0;
      miss_q <= '0;
      for (int i = 0; i < NUM_TONES; i++) acc_q[i] <= '0;
    end else if (!running) begin
      hp_q   <= '0;
      win_q  <= '0;
      miss_q <= '0;
      for (int i = 0; i < NUM_TONES; i++) acc_q[i] <= '0;
    end else begin
      if (tone_edge)
        hp_q <= HP_ONE;
      else if (state_q == ST_MEASURE && hp_q != HP_MAX)
        hp_q <= hp_q + HP_ONE;
      win_q  <= win_end ? '0 : (win_q + WIN_ONE);
      miss_q <= win_end ? '0 : miss_sum;
      for (int i = 0; i < NUM_TONES; i++) acc_q[i] <= win_end ? '0 : acc_sum[i];
    end
  end

  // A new snapshot replaces any pending result; overrun records whether one was lost.
  always_ff @(posedge clock) begin
    if (clear) begin
      res_ticks_q   <= '0;
      res_miss_q    <= '0;
      res_dom_q     <= '0;
      res_dom_vld_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_overrun_q <= 1'b0;
    end else if (win_end) begin
      res_ticks_q   <= ticks_snap;
      res_miss_q    <= miss_sum;
      res_dom_q     <= dom_idx;
      res_dom_vld_q <= dom_any;
      res_valid_q   <= 1'b1;
      res_overrun_q <= res_valid_q && !res.result_ready;
    end else if (res.result_ready) begin
      res_valid_q   <= 1'b0;
    end
  end

  assign res.result_ticks   = res_ticks_q;
  assign res.result_miss    = res_miss_q;
  assign res.result_dom     = res_dom_q;
  assign res.result_dom_vld = res_dom_vld_q;
  assign res.result_valid   = res_valid_q;
  assign res.result_overrun = res_overrun_q;

endmodule

// File: tb/tb_multi_tone_analyzer.sv
// Self-checking bench for multi_tone_analyzer: a table of tone patterns plus hand
// sequences for overrun, clear and enable drop, with results checked from a scoreboard.
module tb_multi_tone_analyzer;

  localparam int NUM_TONES    = 2;
  localparam int CNT_W        = 16;
  localparam int ACC_W        = 32;
  localparam int WINDOW_TICKS = 1000;
  localparam int TOL_SHIFT    = 2;
  localparam int NUM_VECS     = 9;

  // bin: 0/1 = tone bin expected to collect ticks, 2 = miss counter, 3 = nothing at all
  typedef struct {
    int t0;
    int t1;
    int hp;
    int bin;
    int lo;
    int hi;
    int dom;
    bit dom_vld;
  } vec_t;

  typedef struct {
    int bin;
    int lo;
    int hi;
    int dom;
    bit dom_vld;
    bit overrun;
  } exp_t;

  logic                       clock;
  logic                       clear;
  logic                       enable;
  logic                       sample_data;
  logic [NUM_TONES*CNT_W-1:0] cfg_half_period;

  multi_tone_analyzer_if #(.NUM_TONES(NUM_TONES), .ACC_W(ACC_W)) rif ();

  multi_tone_analyzer #(
    .NUM_TONES    (NUM_TONES),
    .CNT_W        (CNT_W),
    .ACC_W        (ACC_W),
    .WINDOW_TICKS (WINDOW_TICKS),
    .TOL_SHIFT    (TOL_SHIFT)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .enable          (enable),
    .sample_data     (sample_data),
    .cfg_half_period (cfg_half_period),
    .res             (rif.master)
  );

  int   compared   = 0;
  int   mismatched = 0;
  int   consumed   = 0;
  int   cyc        = 0;
  int   last_cons  = 0;
  int   prev_cons  = 0;
  int   tone_hp    = 0;
  int   gen_cnt    = 0;
  exp_t exp_q[$];
  vec_t vecs[NUM_VECS];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Square-wave source: sample_data toggles every tone_hp cycles, constant when tone_hp == 0.
  initial begin
    sample_data = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (tone_hp == 0) begin
        gen_cnt = 0;
      end else begin
        gen_cnt++;
        if (gen_cnt >= tone_hp) begin
          sample_data = ~sample_data;
          gen_cnt     = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run still active at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_eq(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic check_range(input string name, input longint actual,
                             input longint lo, input longint hi);
    compared++;
    if (actual < lo || actual > hi) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check_range("ticks0", rif.result_ticks[ACC_W-1:0],
                (e.bin == 0) ? e.lo : 0, (e.bin == 0) ? e.hi : 0);
    check_range("ticks1", rif.result_ticks[2*ACC_W-1:ACC_W],
                (e.bin == 1) ? e.lo : 0, (e.bin == 1) ? e.hi : 0);
    check_range("miss", rif.result_miss,
                (e.bin == 2) ? e.lo : 0, (e.bin == 2) ? e.hi : 0);
    check_eq("dom", rif.result_dom, e.dom);
    check_eq("dom_vld", rif.result_dom_vld, e.dom_vld);
    check_eq("overrun", rif.result_overrun, e.overrun);
  endtask

  task automatic check_zero(input string name);
    check_eq({name, "_valid"}, rif.result_valid, 0);
    check_eq({name, "_overrun"}, rif.result_overrun, 0);
    check_eq({name, "_dom_vld"}, rif.result_dom_vld, 0);
    check_eq({name, "_dom"}, rif.result_dom, 0);
    check_eq({name, "_ticks0"}, rif.result_ticks[ACC_W-1:0], 0);
    check_eq({name, "_ticks1"}, rif.result_ticks[2*ACC_W-1:ACC_W], 0);
    check_eq({name, "_miss"}, rif.result_miss, 0);
  endtask

  // Consumer side: a result is taken on any cycle where valid and ready are both high.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (rif.result_valid && rif.result_ready) begin
        prev_cons = last_cons;
        last_cons = cyc;
        consumed++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_result: got a result at cycle %0d, required none", cyc);
        end else begin
          checkOutput(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    step();
    clear  = 1'b1;
    enable = 1'b0;
    step();
    step();
    clear  = 1'b0;
  endtask

  task automatic set_cfg(input int t0, input int t1);
    cfg_half_period = {16'(t1), 16'(t0)};
  endtask

  function automatic exp_t mk_exp(input int bin, input int lo, input int hi, input int dom,
                                  input bit dom_vld, input bit overrun);
    exp_t e;
    e.bin     = bin;
    e.lo      = lo;
    e.hi      = hi;
    e.dom     = dom;
    e.dom_vld = dom_vld;
    e.overrun = overrun;
    return e;
  endfunction

  task automatic wait_results(input int target, input int budget, input string name);
    int n = 0;
    while (consumed < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (consumed < target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got %0d results, required %0d", name, consumed, target);
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input int exp_n, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rif.result_valid && n < budget);
    if (!rif.result_valid) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no result in %0d cycles, required one", name, n);
    end else begin
      check_eq({name, "_latency"}, n, exp_n);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   target;
    tone_hp = v.hp;
    reset_dut();
    set_cfg(v.t0, v.t1);
    rif.result_ready = 1'b1;
    e = mk_exp(v.bin, v.lo, v.hi, v.dom, v.dom_vld, 1'b0);
    exp_q.push_back(e);
    exp_q.push_back(e);
    target = consumed + 2;
    enable = 1'b1;
    wait_results(target, 2300, "vector");
    if (consumed >= target) check_eq("result_period", last_cons - prev_cons, WINDOW_TICKS);
    enable = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    int   target;

    clear            = 1'b1;
    enable           = 1'b0;
    rif.result_ready = 1'b1;
    set_cfg(10, 25);

    vecs[0] = '{10, 25, 10, 0, 970, 1000, 0, 1'b1};
    vecs[1] = '{10, 25, 27, 1, 900, 1026, 1, 1'b1};
    vecs[2] = '{10, 25, 40, 2, 900, 1040, 0, 1'b0};
    vecs[3] = '{10, 25,  0, 3,   0,    0, 0, 1'b0};
    vecs[4] = '{10, 25, 12, 0, 950, 1008, 0, 1'b1};
    vecs[5] = '{10, 25, 13, 2, 900, 1040, 0, 1'b0};
    vecs[6] = '{10, 25, 19, 1, 900, 1040, 1, 1'b1};
    vecs[7] = '{10, 25, 18, 2, 900, 1040, 0, 1'b0};
    vecs[8] = '{20, 20, 20, 0, 900, 1040, 0, 1'b1};

    $display("[TB] reset state");
    reset_dut();
    @(negedge clock);
    check_zero("reset");

    $display("[TB] table of tone patterns");
    for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i]);

    $display("[TB] overrun with ready held low");
    tone_hp = 10;
    reset_dut();
    set_cfg(10, 25);
    rif.result_ready = 1'b0;
    enable = 1'b1;
    wait_valid(1100, 1002, "first_window");
    exp_q.push_back(mk_exp(0, 990, 1000, 0, 1'b1, 1'b1));
    n = 0;
    while (!rif.result_overrun && n < 1100) begin
      @(negedge clock);
      n++;
    end
    check_eq("overrun_set", rif.result_overrun, 1);
    check_eq("overrun_valid_held", rif.result_valid, 1);
    check_eq("overrun_gap", n, WINDOW_TICKS);
    step();
    rif.result_ready = 1'b1;
    step();
    rif.result_ready = 1'b0;
    @(negedge clock);
    check_eq("valid_after_ready", rif.result_valid, 0);
    exp_q.push_back(mk_exp(0, 990, 1000, 0, 1'b1, 1'b0));
    target = consumed + 1;
    rif.result_ready = 1'b1;
    wait_results(target, 1100, "after_overrun");
    enable = 1'b0;

    $display("[TB] clear in the middle of a window");
    tone_hp = 10;
    reset_dut();
    exp_q.push_back(mk_exp(0, 970, 1000, 0, 1'b1, 1'b0));
    target = consumed + 1;
    enable = 1'b1;
    wait_results(target, 1100, "pre_clear");
    repeat (500) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clock);
    check_zero("mid_clear");
    exp_q.push_back(mk_exp(0, 970, 1000, 0, 1'b1, 1'b0));
    target = consumed + 1;
    wait_valid(1100, 1001, "after_clear");
    wait_results(target, 10, "after_clear");
    enable = 1'b0;

    $display("[TB] enable dropped mid-window");
    tone_hp = 10;
    reset_dut();
    enable = 1'b1;
    repeat (600) step();
    enable = 1'b0;
    repeat (20) step();
    exp_q.push_back(mk_exp(0, 970, 1000, 0, 1'b1, 1'b0));
    target = consumed + 1;
    enable = 1'b1;
    wait_valid(1100, 1002, "rearm");
    wait_results(target, 10, "rearm");
    enable = 1'b0;

    check_eq("scoreboard_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
